// File: rtl/imm_types_pkg.sv
// Shared immediate-type definitions for the immediate generation and encoding units.
// Holds the SELECT encodings, bus widths and the S1 request payload.
package imm_types_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned IMM_W   = 32;
   localparam int unsigned SEL_W   = 3;

   // Immediate-type select; values 3'b101..3'b111 are invalid.
   typedef enum logic [SEL_W-1:0] {
      IMM_U = 3'b000,
      IMM_J = 3'b001,
      IMM_I = 3'b010,
      IMM_B = 3'b011,
      IMM_S = 3'b100
   } imm_sel_e;

   // Payload captured by the input stage.
   typedef struct packed {
      logic [INSTR_W-1:0] base;
      logic [IMM_W-1:0]   imm;
      logic [SEL_W-1:0]   sel;
   } imm_req_t;

endpackage

// File: rtl/immediate_field_packer.sv
// Combinational packer: scatters an immediate into the RV32 field positions of
// the selected type on top of a base instruction, and flags unrepresentable values.
// Ports:
//   base          base instruction, non-immediate bits pass through
//   imm           two's complement immediate
//   sel           immediate-type select (imm_sel_e encodings, others invalid)
//   instr_c       encoded instruction (invalid sel: base unchanged)
//   range_error_c immediate not representable for sel (0 unless IMM_RANGE_CHECK_EN)
// Configuration: IMM_RANGE_CHECK_EN builds the range checker.
module immediate_field_packer
   import imm_types_pkg::*;
(
   input  logic [INSTR_W-1:0] base,
   input  logic [IMM_W-1:0]   imm,
   input  logic [SEL_W-1:0]   sel,
   output logic [INSTR_W-1:0] instr_c,
   output logic               range_error_c
);

   // Field scatter: overwrite only the immediate-bearing bits of the base word.
   always_comb begin
      instr_c = base;
      case (sel)
         IMM_I: instr_c[31:20] = imm[11:0];
         IMM_S: begin
            instr_c[31:25] = imm[11:5];
            instr_c[11:7]  = imm[4:0];
         end
         IMM_B: begin
            instr_c[31]    = imm[12];
            instr_c[30:25] = imm[10:5];
            instr_c[11:8]  = imm[4:1];
            instr_c[7]     = imm[11];
         end
         IMM_U: instr_c[31:12] = imm[31:12];
         IMM_J: begin
            instr_c[31]    = imm[20];
            instr_c[30:21] = imm[10:1];
            instr_c[20]    = imm[11];
            instr_c[19:12] = imm[19:12];
         end
         default: ;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   logic fits_12;
   logic fits_13;
   logic fits_21;

   // A value fits an N-bit signed field when every bit from N-1 upward is a copy of the sign.
   assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

   // Branch/jump offsets are halfword aligned; U carries only the upper 20 bits.
   always_comb begin
      range_error_c = 1'b1;
      case (sel)
         IMM_I, IMM_S: range_error_c = ~fits_12;
         IMM_B:        range_error_c = ~(fits_13 & ~imm[0]);
         IMM_J:        range_error_c = ~(fits_21 & ~imm[0]);
         IMM_U:        range_error_c = |imm[11:0];
         default:      range_error_c = 1'b1;
      endcase
   end
`else
   logic unused_imm_lsb;

   // imm[0] only feeds the alignment check.
   assign unused_imm_lsb = imm[0];
   assign range_error_c  = 1'b0;
`endif

endmodule

// File: rtl/immediate_encoding_unit.sv
// Two-stage pipelined immediate encoder (inverse of the immediate generation unit).
// S1 registers the request on an input handshake; S2 registers the packed word.
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset
//   IN_VALID/READY input handshake (IN_READY combinational, low during reset)
//   IN_BASE        base instruction
//   IN_IMM         two's complement immediate
//   IN_SELECT      immediate-type select
//   OUT_VALID/READY output handshake
//   OUT_INSTR      encoded instruction
//   OUT_ERROR      range error for the delivered word
//   ERR_COUNT      saturating count of delivered words with OUT_ERROR=1
// Configuration: IMM_RANGE_CHECK_EN enables OUT_ERROR/ERR_COUNT; otherwise both are 0.
module immediate_encoding_unit
   import imm_types_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [INSTR_W-1:0] IN_BASE,
   input  logic [IMM_W-1:0]   IN_IMM,
   input  logic [SEL_W-1:0]   IN_SELECT,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [INSTR_W-1:0] OUT_INSTR,
   output logic               OUT_ERROR,
   output logic [CNT_W-1:0]   ERR_COUNT
);

   logic               s1_valid;
   imm_req_t           s1_req;
   logic               s1_adv_c;
   logic               s2_adv_c;
   logic [INSTR_W-1:0] pack_instr;
   logic               pack_err;

   // Pipeline advance: each stage moves when empty or when its consumer drains it.
   assign s2_adv_c = ~OUT_VALID | OUT_READY;
   assign s1_adv_c = ~s1_valid | s2_adv_c;
   assign IN_READY = ~RESET & s1_adv_c;

   // S1: request register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1_valid <= 1'b0;
         s1_req   <= '0;
      end else if (s1_adv_c) begin
         s1_valid <= IN_VALID;
         if (IN_VALID) begin
            s1_req <= '{base: IN_BASE, imm: IN_IMM, sel: IN_SELECT};
         end
      end
   end

   immediate_field_packer u_packer (
      .base          (s1_req.base),
      .imm           (s1_req.imm),
      .sel           (s1_req.sel),
      .instr_c       (pack_instr),
      .range_error_c (pack_err)
   );

   // S2: output word register; data only reloads when a real word moves in.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OUT_VALID <= 1'b0;
         OUT_INSTR <= '0;
      end else if (s2_adv_c) begin
         OUT_VALID <= s1_valid;
         if (s1_valid) begin
            OUT_INSTR <= pack_instr;
         end
      end
   end

`ifdef IMM_RANGE_CHECK_EN
   // S2 error flag, travels with OUT_INSTR.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OUT_ERROR <= 1'b0;
      end else if (s2_adv_c && s1_valid) begin
         OUT_ERROR <= pack_err;
      end
   end

   // Saturating count of delivered erroneous words.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ERR_COUNT <= '0;
      end else if (OUT_VALID && OUT_READY && OUT_ERROR && (ERR_COUNT != '1)) begin
         ERR_COUNT <= ERR_COUNT + CNT_W'(1);
      end
   end
`else
   logic unused_pack_err;

   assign unused_pack_err = pack_err;
   assign OUT_ERROR       = 1'b0;
   assign ERR_COUNT       = '0;
`endif

endmodule

// File: tb/tb_immediate_encoding_unit.sv
// Self-checking bench for immediate_encoding_unit: directed vectors, backpressure,
// throughput, random stress and mid-flight reset against a bit-map reference model.
module tb_immediate_encoding_unit;
   import imm_types_pkg::*;

   localparam int unsigned CNT_W = 4;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             IN_VALID;
   logic             IN_READY;
   logic [31:0]      IN_BASE;
   logic [31:0]      IN_IMM;
   logic [2:0]       IN_SELECT;
   logic             OUT_VALID;
   logic             OUT_READY = 1'b1;
   logic [31:0]      OUT_INSTR;
   logic             OUT_ERROR;
   logic [CNT_W-1:0] ERR_COUNT;

   immediate_encoding_unit #(.CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_BASE   (IN_BASE),
      .IN_IMM    (IN_IMM),
      .IN_SELECT (IN_SELECT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_INSTR (OUT_INSTR),
      .OUT_ERROR (OUT_ERROR),
      .ERR_COUNT (ERR_COUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [31:0] imm;
      logic [2:0]  sel;
      int          acc_cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          model_cnt = 0;
   int          n_acc = 0;
   bit          lat_check = 0;
   bit          stall_prev = 0;
   bit          rdy_rand = 0;
   logic        rdy_force = 1'b1;
   logic [31:0] held_instr;
   logic        held_err;

`ifdef IMM_RANGE_CHECK_EN
   localparam bit CHECK_ON = 1'b1;
`else
   localparam bit CHECK_ON = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Which immediate bit lands in instruction bit p for a given type (-1: base bit).
   function automatic int src_bit(input logic [2:0] sel, input int p);
      case (sel)
         IMM_U: return (p >= 12) ? p : -1;
         IMM_I: return (p >= 20) ? p - 20 : -1;
         IMM_S: begin
            if (p >= 25) return p - 20;
            if (p >= 7 && p <= 11) return p - 7;
            return -1;
         end
         IMM_B: begin
            if (p == 31) return 12;
            if (p == 7) return 11;
            if (p >= 25 && p <= 30) return p - 20;
            if (p >= 8 && p <= 11) return p - 7;
            return -1;
         end
         IMM_J: begin
            if (p == 31) return 20;
            if (p == 20) return 11;
            if (p >= 21 && p <= 30) return p - 20;
            if (p >= 12 && p <= 19) return p;
            return -1;
         end
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] model_encode(input logic [31:0] b, input logic [31:0] i,
                                                input logic [2:0] s);
      logic [31:0] r;
      for (int p = 0; p < 32; p++) begin
         int k;
         k = src_bit(s, p);
         r[p] = (k < 0) ? b[p] : i[k];
      end
      return r;
   endfunction

   // Immediate generation unit (decoder side of the round trip).
   function automatic logic [31:0] decode(input logic [31:0] w, input logic [2:0] s);
      case (s)
         IMM_I: return {{20{w[31]}}, w[31:20]};
         IMM_S: return {{20{w[31]}}, w[31:25], w[11:7]};
         IMM_B: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         IMM_U: return {w[31:12], 12'h000};
         IMM_J: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   // Representable exactly when the encode/decode round trip is lossless.
   function automatic logic model_err(input logic [31:0] i, input logic [2:0] s);
      if (s > 3'd4) return 1'b1;
      return decode(model_encode(32'h0, i, s), s) != i;
   endfunction

   always @(posedge CLK) cyc++;

   always @(posedge CLK) begin
      #1;
      OUT_READY = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   // Monitor / scoreboard, sampling mid-cycle.
   always @(negedge CLK) begin
      exp_t e;
      if (RESET) begin
         sb.delete();
         model_cnt = 0;
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", 32'(OUT_VALID), 32'd1);
            chk("hold_instr", OUT_INSTR, held_instr);
            chk("hold_err", 32'(OUT_ERROR), 32'(held_err));
         end
         if (OUT_VALID && OUT_READY) begin
            chk("err_count", 32'(ERR_COUNT), 32'(model_cnt));
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("instr", OUT_INSTR, e.instr);
               chk("err", 32'(OUT_ERROR), 32'(e.err));
               if (lat_check) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
               if (!model_err(e.imm, e.sel)) chk("roundtrip", decode(OUT_INSTR, e.sel), e.imm);
               if (e.err && model_cnt < (1 << CNT_W) - 1) model_cnt++;
            end
         end
         stall_prev = OUT_VALID && !OUT_READY;
         held_instr = OUT_INSTR;
         held_err = OUT_ERROR;
         if (IN_VALID && IN_READY) begin
            e.instr = model_encode(IN_BASE, IN_IMM, IN_SELECT);
            e.err = CHECK_ON ? model_err(IN_IMM, IN_SELECT) : 1'b0;
            e.imm = IN_IMM;
            e.sel = IN_SELECT;
            e.acc_cyc = cyc;
            sb.push_back(e);
            n_acc++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s);
      int n;
      n = 0;
      IN_BASE = b;
      IN_IMM = i;
      IN_SELECT = s;
      IN_VALID = 1'b1;
      @(negedge CLK);
      while (!IN_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) chk("send_timeout", 32'(IN_READY), 32'd1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge CLK);
         n++;
      end
      #1;
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic set_ready(input logic v);
      rdy_force = v;
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic rand_word(output logic [31:0] b, output logic [31:0] i, output logic [2:0] s);
      logic [31:0] r;
      r = $urandom;
      b = $urandom;
      s = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
         0: i = r;
         1: i = {{20{r[11]}}, r[11:0]};
         2: i = {r[31:12], 12'h000};
         3: i = {{19{r[12]}}, r[12:1], 1'b0};
         default: i = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
   endtask

   // Directed vectors: five legal encodings then four range errors.
   logic [31:0] d_base[9];
   logic [31:0] d_imm[9];
   logic [2:0]  d_sel[9];
   logic [31:0] d_instr[9];
   logic        d_err[9];

   initial begin
      logic [31:0] b, i;
      logic [2:0]  s;
      int          a0, t0, n;

      d_base  = '{32'h00000013, 32'h00002023, 32'h00000063, 32'h0000006F, 32'h00000037,
                  32'h00000013, 32'h00000063, 32'h00000037, 32'h00000033};
      d_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFE, 32'h00000800, 32'h12345000,
                  32'h00000800, 32'h00000003, 32'h00000001, 32'h12345678};
      d_sel   = '{3'b010, 3'b100, 3'b011, 3'b001, 3'b000, 3'b010, 3'b011, 3'b000, 3'b111};
      d_instr = '{32'hFFF00013, 32'hFE002E23, 32'hFE000FE3, 32'h0010006F, 32'h12345037,
                  32'h80000013, 32'h00000163, 32'h00000037, 32'h00000033};
      d_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      IN_VALID = 1'b0;
      IN_BASE = '0;
      IN_IMM = '0;
      IN_SELECT = '0;
      RESET = 1'b0;
      #1 RESET = 1'b1;
      #1;
      chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_out_instr", OUT_INSTR, 32'd0);
      chk("rst_out_error", 32'(OUT_ERROR), 32'd0);
      chk("rst_err_count", 32'(ERR_COUNT), 32'd0);
      chk("rst_in_ready", 32'(IN_READY), 32'd0);
      repeat (2) @(posedge CLK);
      #2 RESET = 1'b0;
      @(posedge CLK);
      #1;

      // Directed vectors in isolation.
      lat_check = 1;
      for (int k = 0; k < 9; k++) begin
         send(d_base[k], d_imm[k], d_sel[k]);
         n = 0;
         do begin
            @(negedge CLK);
            n++;
         end while (!OUT_VALID && n < 10);
         chk($sformatf("dir%0d_valid", k), 32'(OUT_VALID), 32'd1);
         chk($sformatf("dir%0d_instr", k), OUT_INSTR, d_instr[k]);
         chk($sformatf("dir%0d_err", k), 32'(OUT_ERROR), 32'(d_err[k] & CHECK_ON));
         @(posedge CLK);
         #1;
      end
      drain();
      chk("err_count_total", 32'(ERR_COUNT), CHECK_ON ? 32'd4 : 32'd0);

      // Backpressure: four words against a stalled sink.
      lat_check = 0;
      set_ready(1'b0);
      a0 = n_acc;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               rand_word(b, i, s);
               send(b, i, s);
            end
         end
         begin
            int m;
            m = 0;
            while (n_acc - a0 < 2 && m < 50) begin
               @(posedge CLK);
               #3;
               m++;
            end
            chk("bp_in_ready", 32'(IN_READY), 32'd0);
            chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
            repeat (3) @(posedge CLK);
            #1 rdy_force = 1'b1;
         end
      join
      drain();
      chk("bp_accepted", 32'(n_acc - a0), 32'd4);

      // Throughput: back-to-back words with the sink always ready.
      set_ready(1'b1);
      lat_check = 1;
      t0 = cyc;
      for (int k = 0; k < 100; k++) begin
         rand_word(b, i, s);
         send(b, i, s);
      end
      chk("throughput_cycles", 32'(cyc - t0), 32'd100);
      drain();
      lat_check = 0;

      // Random stress with bursty source and random sink readiness.
      rdy_rand = 1;
      for (int k = 0; k < 300; k++) begin
         rand_word(b, i, s);
         send(b, i, s);
         repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
         end
      end
      drain();
      rdy_rand = 0;

      // Reset with both stages occupied.
      set_ready(1'b0);
      for (int k = 0; k < 2; k++) begin
         rand_word(b, i, s);
         send(b, i, s);
      end
      chk("pre_rst_full", 32'(IN_READY), 32'd0);
      #2 RESET = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("mid_rst_err_count", 32'(ERR_COUNT), 32'd0);
      chk("mid_rst_in_ready", 32'(IN_READY), 32'd0);
      @(negedge CLK);
      @(posedge CLK);
      #2 RESET = 1'b0;
      set_ready(1'b1);
      lat_check = 1;
      send(32'h00000013, 32'h000007FF, 3'b010);
      drain();
      lat_check = 0;
      repeat (3) @(posedge CLK);
      #1;
      chk("final_idle", 32'(OUT_VALID), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
